// File: rtl/pc_branch_unit.sv
// pc_branch_unit
//   Program-counter and branch-resolution stage of the single-cycle CPU.
//   Holds the PC and a {N,V,C,Z} flag register. Evaluates branch conditions
//   on either the live ALU flags or the saved flags. Selects the next PC:
//   jump target, taken-branch target, or sequential PC+PC_STEP.
//   A two-state RUN/HALTED FSM freezes the stage after a HALT instruction.
//
// Ports
//   Clock, Reset      rising-edge clock; synchronous active-high reset
//   Enable            1 = advance this cycle, 0 = stall (all state held)
//   ALUZero/Overflow/CarryOut/Negative   live ALU condition outputs
//   FlagWrite         latch the live ALU flags into Flags
//   Branch, BranchCond, BranchUseSaved, BranchOffset   conditional branch
//   Jump, JumpTarget  unconditional absolute jump
//   Halt              current instruction is HALT
//   PC                registered current instruction address
//   PCNext            combinational next-PC value
//   PCPlus            PC + PC_STEP (link value)
//   Flags             registered {N,V,C,Z}
//   Taken             combinational: a redirect is selected this cycle
//   Halted            registered: 1 while in the HALTED state

module pc_branch_unit #(
    parameter int unsigned                PC_WIDTH     = 24,
    parameter logic [PC_WIDTH-1:0]        RESET_VECTOR = '0,
    parameter int unsigned                PC_STEP      = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Enable,
    input  logic                ALUZero,
    input  logic                ALUOverflow,
    input  logic                ALUCarryOut,
    input  logic                ALUNegative,
    input  logic                FlagWrite,
    input  logic                Branch,
    input  logic [2:0]          BranchCond,
    input  logic                BranchUseSaved,
    input  logic [15:0]         BranchOffset,
    input  logic                Jump,
    input  logic [PC_WIDTH-1:0] JumpTarget,
    input  logic                Halt,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PCNext,
    output logic [PC_WIDTH-1:0] PCPlus,
    output logic [3:0]          Flags,
    output logic                Taken,
    output logic                Halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [PC_WIDTH-1:0]   pc_nxt;
    logic [PC_WIDTH-1:0]   offset_ext;
    logic [PC_WIDTH-1:0]   branch_target;
    logic                  flags_we;
    logic                  taken;
    logic                  cond_true;
    logic                  fz, fv, fc, fn;

    // All PC arithmetic is modulo 2^PC_WIDTH; carry out is simply dropped.
    assign offset_ext    = {{(PC_WIDTH-16){BranchOffset[15]}}, BranchOffset};
    assign PCPlus        = PC + PC_WIDTH'(PC_STEP);
    assign branch_target = PCPlus + offset_ext;

    // Condition source: saved flags are the register contents before any
    // write at this edge, so a same-cycle FlagWrite is not visible here.
    always_comb begin
        fn = ALUNegative;
        fv = ALUOverflow;
        fc = ALUCarryOut;
        fz = ALUZero;
        if (BranchUseSaved) begin
            fn = Flags[3];
            fv = Flags[2];
            fc = Flags[1];
            fz = Flags[0];
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (BranchCond)
            3'b000:  cond_true = fz;
            3'b001:  cond_true = !fz;
            3'b010:  cond_true = fn ^ fv;
            3'b011:  cond_true = !(fn ^ fv);
            3'b100:  cond_true = !fc;
            3'b101:  cond_true = fc;
            3'b110:  cond_true = fv;
            default: cond_true = 1'b1;
        endcase
    end

    // Next-state / next-PC. Stall, HALT and the HALTED state all hold PC.
    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        taken     = 1'b0;
        flags_we  = 1'b0;
        if (state == ST_RUN && Enable) begin
            if (Halt) begin
                state_nxt = ST_HALTED;
            end else begin
                flags_we = FlagWrite;
                if (Jump) begin
                    taken  = 1'b1;
                    pc_nxt = JumpTarget;
                end else if (Branch && cond_true) begin
                    taken  = 1'b1;
                    pc_nxt = branch_target;
                end else begin
                    pc_nxt = PCPlus;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_RUN;
            PC    <= RESET_VECTOR;
            Flags <= '0;
        end else begin
            state <= state_nxt;
            PC    <= pc_nxt;
            if (flags_we) begin
                Flags <= {ALUNegative, ALUOverflow, ALUCarryOut, ALUZero};
            end
        end
    end

    assign PCNext = pc_nxt;
    assign Taken  = taken;
    assign Halted = (state == ST_HALTED);

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

    logic        Clock = 1'b0;
    logic        Reset, Enable;
    logic        ALUZero, ALUOverflow, ALUCarryOut, ALUNegative;
    logic        FlagWrite, Branch, BranchUseSaved, Jump, Halt;
    logic [2:0]  BranchCond;
    logic [15:0] BranchOffset;
    logic [23:0] JumpTarget;
    logic [23:0] PC, PCNext, PCPlus;
    logic [3:0]  Flags;
    logic        Taken, Halted;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    pc_branch_unit #(
        .PC_WIDTH     (24),
        .RESET_VECTOR (24'h000000),
        .PC_STEP      (1)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Enable         (Enable),
        .ALUZero        (ALUZero),
        .ALUOverflow    (ALUOverflow),
        .ALUCarryOut    (ALUCarryOut),
        .ALUNegative    (ALUNegative),
        .FlagWrite      (FlagWrite),
        .Branch         (Branch),
        .BranchCond     (BranchCond),
        .BranchUseSaved (BranchUseSaved),
        .BranchOffset   (BranchOffset),
        .Jump           (Jump),
        .JumpTarget     (JumpTarget),
        .Halt           (Halt),
        .PC             (PC),
        .PCNext         (PCNext),
        .PCPlus         (PCPlus),
        .Flags          (Flags),
        .Taken          (Taken),
        .Halted         (Halted)
    );

    always #5 Clock = ~Clock;

    task automatic idle();
        Reset = 0; Enable = 1;
        ALUZero = 0; ALUOverflow = 0; ALUCarryOut = 0; ALUNegative = 0;
        FlagWrite = 0; Branch = 0; BranchCond = 3'b000; BranchUseSaved = 0;
        BranchOffset = 16'h0000; Jump = 0; JumpTarget = 24'h0; Halt = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic go_to(input logic [23:0] addr);
        idle();
        Jump = 1; JumpTarget = addr;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        Reset = 1;
        tick();
        Reset = 0;
        total_cnt++;
        if (PC !== 24'h000000) $display("FAIL reset_pc: got %h want 000000", PC);
        else pass_cnt++;
        total_cnt++;
        if (Flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", Flags);
        else pass_cnt++;
        total_cnt++;
        if (Halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", Halted);
        else pass_cnt++;
    endtask

    task automatic test_sequential();
        idle();
        total_cnt++;
        if (PCPlus !== 24'd1) $display("FAIL seq_pcplus: got %h want 000001", PCPlus);
        else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total_cnt++;
            if (PC !== 24'(i)) $display("FAIL seq_pc%0d: got %h want %h", i, PC, 24'(i));
            else pass_cnt++;
        end
        total_cnt++;
        if (Flags !== 4'b0000 || Halted !== 1'b0)
            $display("FAIL seq_state: got flags=%b halted=%b want 0000/0", Flags, Halted);
        else pass_cnt++;
    endtask

    task automatic test_branch_eq();
        go_to(24'd10);
        Branch = 1; BranchCond = 3'b000; ALUZero = 1; BranchOffset = 16'hFFFD;
        #1;
        total_cnt++;
        if (Taken !== 1'b1 || PCNext !== 24'd8)
            $display("FAIL beq_taken_comb: got taken=%b next=%h want 1/000008", Taken, PCNext);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (PC !== 24'd8) $display("FAIL beq_taken_pc: got %h want 000008", PC);
        else pass_cnt++;

        go_to(24'd10);
        Branch = 1; BranchCond = 3'b000; ALUZero = 0; BranchOffset = 16'hFFFD;
        #1;
        total_cnt++;
        if (Taken !== 1'b0 || PCNext !== 24'd11)
            $display("FAIL beq_not_comb: got taken=%b next=%h want 0/00000b", Taken, PCNext);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (PC !== 24'd11) $display("FAIL beq_not_pc: got %h want 00000b", PC);
        else pass_cnt++;
    endtask

    task automatic test_saved_flags();
        go_to(24'd12);
        FlagWrite = 1; ALUNegative = 1;
        tick();
        idle();
        total_cnt++;
        if (Flags !== 4'b1000) $display("FAIL flags_load: got %b want 1000", Flags);
        else pass_cnt++;
        // Live flags contradict the saved ones (C=1, N=0) so the source matters.
        Branch = 1; BranchUseSaved = 1; BranchOffset = 16'd5; ALUCarryOut = 1;
        BranchCond = 3'b100; #1;
        total_cnt++;
        if (Taken !== 1'b1) $display("FAIL saved_ltu: got %b want 1", Taken);
        else pass_cnt++;
        BranchCond = 3'b010; #1;
        total_cnt++;
        if (Taken !== 1'b1) $display("FAIL saved_lt: got %b want 1", Taken);
        else pass_cnt++;
        BranchCond = 3'b011; #1;
        total_cnt++;
        if (Taken !== 1'b0 || PCNext !== 24'd14)
            $display("FAIL saved_ge: got taken=%b next=%h want 0/00000e", Taken, PCNext);
        else pass_cnt++;
        BranchCond = 3'b100;
        tick();
        total_cnt++;
        if (PC !== 24'd19) $display("FAIL saved_ltu_pc: got %h want 000013", PC);
        else pass_cnt++;
        // Same-cycle write: GEU must see old C=0, register then takes live C=1.
        idle();
        Branch = 1; BranchUseSaved = 1; BranchCond = 3'b101; BranchOffset = 16'd5;
        FlagWrite = 1; ALUCarryOut = 1;
        #1;
        total_cnt++;
        if (Taken !== 1'b0 || PCNext !== 24'd20)
            $display("FAIL saved_old: got taken=%b next=%h want 0/000014", Taken, PCNext);
        else pass_cnt++;
        tick();
        idle();
        total_cnt++;
        if (PC !== 24'd20 || Flags !== 4'b0010)
            $display("FAIL saved_write: got pc=%h flags=%b want 000014/0010", PC, Flags);
        else pass_cnt++;
    endtask

    task automatic test_jump_priority();
        idle();
        Jump = 1; JumpTarget = 24'h00ABCD;
        Branch = 1; BranchCond = 3'b111; BranchOffset = 16'd5;
        #1;
        total_cnt++;
        if (Taken !== 1'b1 || PCNext !== 24'h00ABCD)
            $display("FAIL jump_comb: got taken=%b next=%h want 1/00abcd", Taken, PCNext);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (PC !== 24'h00ABCD) $display("FAIL jump_pc: got %h want 00abcd", PC);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        go_to(24'hFFFFFF);
        total_cnt++;
        if (PCPlus !== 24'h000000) $display("FAIL wrap_pcplus: got %h want 000000", PCPlus);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (PC !== 24'h000000) $display("FAIL wrap_seq: got %h want 000000", PC);
        else pass_cnt++;
        go_to(24'hFFFFFE);
        Branch = 1; BranchCond = 3'b111; BranchOffset = 16'd3;
        tick();
        total_cnt++;
        if (PC !== 24'h000002) $display("FAIL wrap_branch: got %h want 000002", PC);
        else pass_cnt++;
        // 2 + 1 - 6 wraps below zero.
        BranchOffset = 16'hFFFA;
        tick();
        idle();
        total_cnt++;
        if (PC !== 24'hFFFFFD) $display("FAIL wrap_neg: got %h want fffffd", PC);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        go_to(24'd7);
        Enable = 0; FlagWrite = 1; Jump = 1; JumpTarget = 24'h55;
        ALUZero = 1; ALUOverflow = 1; ALUCarryOut = 1; ALUNegative = 1;
        #1;
        total_cnt++;
        if (Taken !== 1'b0 || PCNext !== 24'd7)
            $display("FAIL stall_comb: got taken=%b next=%h want 0/000007", Taken, PCNext);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (PC !== 24'd7 || Flags !== 4'b0010)
                $display("FAIL stall_hold%0d: got pc=%h flags=%b want 000007/0010", i, PC, Flags);
            else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_halt();
        go_to(24'd9);
        Halt = 1; Jump = 1; JumpTarget = 24'h33; FlagWrite = 1; ALUZero = 1;
        #1;
        total_cnt++;
        if (Taken !== 1'b0 || PCNext !== 24'd9)
            $display("FAIL halt_comb: got taken=%b next=%h want 0/000009", Taken, PCNext);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (PC !== 24'd9 || Halted !== 1'b1 || Flags !== 4'b0010)
            $display("FAIL halt_enter: got pc=%h halted=%b flags=%b want 000009/1/0010", PC, Halted, Flags);
        else pass_cnt++;
        Halt = 0; Branch = 1; BranchCond = 3'b111; BranchOffset = 16'd4;
        ALUNegative = 1; ALUCarryOut = 1;
        #1;
        total_cnt++;
        if (Taken !== 1'b0 || PCNext !== 24'd9)
            $display("FAIL halted_comb: got taken=%b next=%h want 0/000009", Taken, PCNext);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (PC !== 24'd9 || Halted !== 1'b1 || Flags !== 4'b0010)
                $display("FAIL halted_hold%0d: got pc=%h halted=%b flags=%b want 000009/1/0010", i, PC, Halted, Flags);
            else pass_cnt++;
        end
        Reset = 1;
        tick();
        idle();
        total_cnt++;
        if (PC !== 24'h000000 || Halted !== 1'b0 || Flags !== 4'b0000)
            $display("FAIL halt_reset: got pc=%h halted=%b flags=%b want 000000/0/0000", PC, Halted, Flags);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (PC !== 24'd1) $display("FAIL post_reset_run: got %h want 000001", PC);
        else pass_cnt++;
    endtask

    initial begin
        idle();
        test_reset();
        test_sequential();
        test_branch_eq();
        test_saved_flags();
        test_jump_priority();
        test_wrap();
        test_stall();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
